// File: rtl/fifo_pkg.sv
// fifo_pkg: default geometry and flow-control thresholds shared by the FIFO family and its benches
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH   = 10;
    localparam int FIFO_DEPTH        = 8;
    localparam int FIFO_ADDR_WIDTH   = 3;
    localparam int FIFO_ALMOST_FULL  = 6;
    localparam int FIFO_ALMOST_EMPTY = 2;
endpackage

// File: rtl/fifo_flow_ctrl_if.sv
// fifo_flow_ctrl_if: producer/consumer handshake and status bundle of the flow-controlled FIFO
interface fifo_flow_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
    logic                  wr_enable;
    logic                  rd_enable;
    logic [DATA_WIDTH-1:0] fifo_data_in;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_valid_out;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  error;

    modport master (
        output wr_enable, rd_enable, fifo_data_in,
        input  fifo_data_out, fifo_valid_out, fifo_count, full, empty,
               almost_full, almost_empty, error
    );

    modport slave (
        input  wr_enable, rd_enable, fifo_data_in,
        output fifo_data_out, fifo_valid_out, fifo_count, full, empty,
               almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port register array, one write port and one synchronous read port, no reset
module fifo_mem #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store on write, capture the addressed word on read; rdata holds otherwise
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo_flow_ctrl.sv
// fifo_flow_ctrl: synchronous FIFO with internal pointers, occupancy count, threshold flags and sticky error
module fifo_flow_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = FIFO_DATA_WIDTH,
    parameter int DEPTH        = FIFO_DEPTH,
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int ALMOST_FULL  = FIFO_ALMOST_FULL,
    parameter int ALMOST_EMPTY = FIFO_ALMOST_EMPTY
) (
    input logic             clk,
    input logic             reset,
    fifo_flow_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH+1)'(ALMOST_EMPTY);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  valid;
    logic                  data_ok;
    logic                  error;

    assign full  = count == CNT_FULL;
    assign empty = count == '0;
    // A full FIFO still takes a write when a read frees a slot on the same edge
    assign rd_ok = bus.rd_enable && !empty;
    assign wr_ok = bus.wr_enable && (!full || rd_ok);

    // Occupancy moves only when exactly one side is accepted
    always_comb begin
        count_next = (wr_ok && !rd_ok) ? count + 1'b1 :
                     (rd_ok && !wr_ok) ? count - 1'b1 : count;
    end

    // Pointer, occupancy, valid and sticky error state; reset discards everything at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid   <= 1'b0;
            data_ok <= 1'b0;
            error   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            valid <= rd_ok;
            if (rd_ok) data_ok <= 1'b1;
            if ((bus.wr_enable && !wr_ok) || (bus.rd_enable && !rd_ok)) error <= 1'b1;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.fifo_data_in),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // The array has no reset, so the output reads zero until a word has been read since reset
    assign bus.fifo_data_out  = data_ok ? rd_data : '0;
    assign bus.fifo_valid_out = valid;
    assign bus.fifo_count     = count;
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.almost_full    = count >= CNT_AF;
    assign bus.almost_empty   = count <= CNT_AE;
    assign bus.error          = error;
endmodule

// File: doc/fifo_flow_ctrl.md
# fifo_flow_ctrl

Parametrised synchronous FIFO for the data path. It replaces the externally pointer-driven FIFO with internally managed read/write pointers, an occupancy count, almost-full/almost-empty thresholds for upstream flow control, and a sticky overflow/underflow error flag. It sits between producer and consumer stages that share one clock.

## Interface
- DATA_WIDTH, 10, word width in bits
- DEPTH, 8, number of entries; power of two, ≥ 4
- ADDR_WIDTH, 3, log2(DEPTH); must match DEPTH
- ALMOST_FULL, 6, almost_full asserts when count ≥ this; range 1..DEPTH-1
- ALMOST_EMPTY, 2, almost_empty asserts when count ≤ this; range 0..DEPTH-2, < ALMOST_FULL

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- wr_enable  in  1  write request
- rd_enable  in  1  read request
- fifo_data_in  in  DATA_WIDTH  write data
- fifo_data_out  out  DATA_WIDTH  read data, registered
- fifo_valid_out  out  1  fifo_data_out holds a newly read word this cycle
- fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- full, empty  out  1 each  count==DEPTH / count==0
- almost_full, almost_empty  out  1 each  threshold flags
- error  out  1  sticky: rejected write or rejected read occurred

## Operation
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=0, count=0, fifo_data_out=0, fifo_valid_out=0, error=0; therefore empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not cleared.
- Write accepted iff wr_enable && (!full || read accepted in the same cycle): mem[wr_ptr] ← fifo_data_in, wr_ptr increments.
- Read accepted iff rd_enable && !empty: fifo_data_out ← mem[rd_ptr], rd_ptr increments, fifo_valid_out=1 on the next cycle. Without an accepted read: fifo_valid_out=0 and fifo_data_out holds its last value.
- Count: +1 on write-only, −1 on read-only, unchanged on both or neither.
- Pointers wrap modulo DEPTH (natural ADDR_WIDTH rollover).
- Empty with rd and wr both active: write accepted, read rejected (no fall-through), error set.
- Full with rd and wr both active: both accepted, count stays DEPTH, no error.
- Full, wr only: write dropped, error set, memory unchanged.
- Empty, rd only: read dropped, error set, fifo_valid_out=0.
- error clears only on reset.
- Flags full/empty/almost_* are decoded combinationally from the count register; no other combinational input-to-output paths.

## Timing
- Write to visibility: a word written at edge N raises count/clears empty after edge N; it is readable from cycle N+1.
- Read latency 1: a read accepted at edge N presents its data and fifo_valid_out on cycle N+1 until edge N+1.
- Flags change on the same edge as count.
- Reset deassertion is taken synchronously by the environment; the first operation is accepted on the first rising edge with reset=1.
- Reset asserted mid-operation: all state is cleared immediately, in-flight read data is discarded, and fifo_valid_out drops without waiting for a clock edge.

## Structure
- Shared constants file (fifo_pkg): default DATA_WIDTH, DEPTH, ADDR_WIDTH, threshold defaults. Reused by the bench and sibling FIFOs.
- Sub-module fifo_mem: simple dual-port register array (one write port, one synchronous read port, no reset). fifo_flow_ctrl holds the pointers, count, flags, error and valid logic.

## Test plan
- Reset check: hold reset=0 for 3 cycles, then release -> count=0, empty=1, almost_empty=1, full=0, error=0, fifo_data_out=0.
- Fill/drain: write 0x090, 0x1A9, 0x239, 0x04F, 0x04D, 0x018, 0x3FF, 0x155, then read 8 -> data returns in the same order, each 1 cycle after its rd_enable. almost_full rises on the 6th write, full on the 8th. almost_empty rises when count reaches 2, empty after the 8th read. error=0.
- Overflow: from full, write 0x2AA with no read -> count stays 8, error=1. The subsequent 8 reads return the original data; 0x2AA never appears.
- Underflow: from empty, rd_enable=1 for 1 cycle -> fifo_valid_out=0, count=0, error=1.
- Simultaneous: at count=8, rd+wr 0x123 -> count stays 8, oldest word is output, error=0. At count=0, rd+wr 0x0F0 -> count=1, fifo_valid_out=0, error=1.
- Wrap and mid-reset: run 20 alternating write/read pairs through DEPTH=8 -> data stays in order across the pointer wrap. Then, with count=5, pulse reset=0 between edges -> all outputs return to reset values immediately.
